ni_beat_link_scheduler: RTL and testbench

Link-side scheduler for the NI slow-link path. It shares one divided-rate flit link among N_REQ local requesters using round-robin arbitration, and generates the per-flit beat timing internally with a clock-divider counter. It owns the live divider value and applies runtime reconfiguration only at packet boundaries. It sits between the NI packet buffers and the link serializer.

---
 rtl/ni_beat_link_scheduler.sv | 111 +++++++++++
 tb/tb_ni_beat_link_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ni_beat_link_scheduler.sv
// Round-robin scheduler for the divided-rate NI slow link: grants one requester per
// packet and times flit beats with an internal divider counter.
module ni_beat_link_scheduler #(
    parameter int N_REQ       = 4,
    parameter int COUNTERWD   = 4,
    parameter int LENWD       = 4,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COUNTERWD-1:0]     cfg_clkdiv,
    input  logic                     cfg_load,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LENWD-1:0]   req_len,
    output logic [N_REQ-1:0]         gnt,
    output logic                     flit_pop,
    output logic                     last_flit,
    output logic                     busy,
    output logic [COUNTERWD-1:0]     cur_clkdiv
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;
    state_t state, state_nx;

    logic [COUNTERWD-1:0] beat_cnt, ediv, pend_div;
    logic [LENWD-1:0]     flit_cnt, len_q;
    logic [IDXW-1:0]      rr_ptr, gnt_idx, sel_idx;
    logic                 sel_vld, pend_vld, beat;
    int                   ix;

    // A programmed divider of 0 runs the link at full rate, same as 1.
    assign ediv      = (cur_clkdiv == '0) ? COUNTERWD'(1) : cur_clkdiv;
    assign beat      = (state == XFER) && (beat_cnt == ediv - COUNTERWD'(1));
    assign flit_pop  = beat;
    assign last_flit = beat && (flit_cnt == len_q);
    assign busy      = (state == XFER);

    // Walk offsets downward so the smallest offset from rr_ptr wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        ix      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            ix = (int'(rr_ptr) + k) % N_REQ;
            if (req[ix]) begin
                sel_vld = 1'b1;
                sel_idx = IDXW'(ix);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sel_vld) state_nx = XFER;
            XFER:    if (last_flit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            beat_cnt   <= '0;
            flit_cnt   <= '0;
            len_q      <= '0;
            rr_ptr     <= '0;
            pend_vld   <= 1'b0;
            pend_div   <= '0;
            cur_clkdiv <= COUNTERWD'(DEFAULT_DIV);
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    flit_cnt <= '0;
                    if (cfg_load) cur_clkdiv <= cfg_clkdiv;
                    if (sel_vld) begin
                        gnt     <= N_REQ'(1) << sel_idx;
                        gnt_idx <= sel_idx;
                        len_q   <= req_len[sel_idx*LENWD +: LENWD];
                    end
                end
                XFER: begin
                    // Divider changes are held off until the packet boundary.
                    if (cfg_load) begin
                        pend_div <= cfg_clkdiv;
                        pend_vld <= 1'b1;
                    end
                    if (beat) begin
                        beat_cnt <= '0;
                        if (!last_flit) flit_cnt <= flit_cnt + LENWD'(1);
                    end else begin
                        beat_cnt <= beat_cnt + COUNTERWD'(1);
                    end
                    if (last_flit) begin
                        gnt      <= '0;
                        rr_ptr   <= (gnt_idx == IDXW'(N_REQ - 1)) ? '0 : gnt_idx + IDXW'(1);
                        pend_vld <= 1'b0;
                        if (cfg_load)      cur_clkdiv <= cfg_clkdiv;
                        else if (pend_vld) cur_clkdiv <= pend_div;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ni_beat_link_scheduler.sv
// Scoreboard bench: a packet-level model predicts grants, lengths and dividers;
// a negedge monitor checks grant, beat timing and last_flit against it.
module tb_ni_beat_link_scheduler;
    localparam int N = 4, CW = 4, LW = 4;

    logic            clk = 1'b0, rst = 1'b0;
    logic [CW-1:0]   cfg_clkdiv = '0;
    logic            cfg_load = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    gnt;
    logic            flit_pop, last_flit, busy;
    logic [CW-1:0]   cur_clkdiv;

    ni_beat_link_scheduler #(.N_REQ(N), .COUNTERWD(CW), .LENWD(LW), .DEFAULT_DIV(1)) dut (
        .clk(clk), .rst(rst), .cfg_clkdiv(cfg_clkdiv), .cfg_load(cfg_load),
        .req(req), .req_len(req_len), .gnt(gnt), .flit_pop(flit_pop),
        .last_flit(last_flit), .busy(busy), .cur_clkdiv(cur_clkdiv)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; int len; int div;} pkt_t;
    pkt_t sb[$];
    pkt_t cur;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int m_free = 0, m_rr = 0, m_div = 1, m_pend = 0;
    bit m_pend_v = 0;
    bit in_pkt = 0, prev_last = 0;
    int off = 0, npop = 0;

    function automatic int ed(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic [N*LW-1:0] lens(input int a, input int b, input int c, input int d);
        logic [N*LW-1:0] v;
        v = '0;
        v[0 +: LW] = a[LW-1:0];
        v[LW +: LW] = b[LW-1:0];
        v[2*LW +: LW] = c[LW-1:0];
        v[3*LW +: LW] = d[LW-1:0];
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_free = 0; m_rr = 0; m_div = 1; m_pend_v = 0;
        sb.delete();
    endtask

    // Packet-level reference: arbitration when idle, divider updates at boundaries.
    task automatic model_eval(input logic [N-1:0] r, input logic [N*LW-1:0] l,
                              input logic ld, input int dv);
        int idx;
        pkt_t p;
        if (cyc >= m_free) begin
            if (m_pend_v) begin m_div = m_pend; m_pend_v = 0; end
            if (ld) m_div = dv;
            if (r != 0) begin
                idx = -1;
                for (int k = 0; k < N; k++)
                    if (idx < 0 && r[(m_rr + k) % N]) idx = (m_rr + k) % N;
                p.idx = idx;
                p.len = int'(l[idx*LW +: LW]);
                p.div = m_div;
                sb.push_back(p);
                m_free = cyc + (p.len + 1) * ed(m_div) + 1;
                m_rr = (idx + 1) % N;
            end
        end else if (ld) begin
            m_pend = dv; m_pend_v = 1;
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*LW-1:0] l,
                        input logic ld, input int dv);
        req = r; req_len = l; cfg_load = ld; cfg_clkdiv = CW'(dv);
        model_eval(r, l, ld, dv);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, 1'b0, 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((cyc < m_free || sb.size() != 0 || in_pkt) && t < 300) begin
            step('0, '0, 1'b0, 0);
            t++;
        end
        chk("drain_in_bound", int'(t < 300), 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_pkt = 0; prev_last = 0;
        end else begin
            if (prev_last) chk("idle_gap_gnt", int'(gnt), 0);
            prev_last = 0;
            if (!in_pkt && gnt != 0) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_grant: gnt=%b required no grant", gnt);
                end else begin
                    cur = sb.pop_front();
                    chk("grant", int'(gnt), 1 << cur.idx);
                    in_pkt = 1; off = 0; npop = 0;
                end
            end
            if (in_pkt) begin
                off++;
                chk("busy", int'(busy), 1);
                chk("gnt_hold", int'(gnt), 1 << cur.idx);
                if (flit_pop) begin
                    npop++;
                    chk("pop_time", off, npop * ed(cur.div));
                    chk("last_flit", int'(last_flit), int'(npop == cur.len + 1));
                    chk("cur_clkdiv", int'(cur_clkdiv), cur.div);
                    if (last_flit) begin in_pkt = 0; prev_last = 1; end
                end else if (off > (cur.len + 1) * ed(cur.div)) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pop_missing: offset %0d, required last pop by %0d",
                             off, (cur.len + 1) * ed(cur.div));
                    in_pkt = 0;
                end
            end else begin
                chk("no_pop_idle", int'(flit_pop), 0);
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_pop", int'(flit_pop), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_div", int'(cur_clkdiv), 1);
        @(posedge clk); #1 rst = 1'b0;

        // Asynchronous reset must restore the default divider without a clock edge.
        step('0, '0, 1'b1, 5);
        chk("load_idle", int'(cur_clkdiv), 5);
        idle(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", int'(gnt), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_div", int'(cur_clkdiv), 1);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        idle(3);

        // Single packet, divider 3.
        step('0, '0, 1'b1, 3);
        step(4'b0010, lens(0, 2, 0, 0), 1'b0, 0);
        drain();

        // Divider 0 behaves as 1.
        step('0, '0, 1'b1, 0);
        chk("div0_read", int'(cur_clkdiv), 0);
        step(4'b0001, lens(3, 0, 0, 0), 1'b0, 0);
        drain();

        // Round-robin fairness.
        step('0, '0, 1'b1, 1);
        repeat (12) step(4'b1111, '0, 1'b0, 0);
        drain();
        repeat (8) step(4'b1010, '0, 1'b0, 0);
        drain();

        // Longest packet and largest divider.
        step(4'b1000, lens(0, 0, 0, 15), 1'b0, 0);
        drain();
        step('0, '0, 1'b1, 15);
        step(4'b0100, lens(0, 0, 1, 0), 1'b0, 0);
        drain();

        // Reconfiguration while busy: last load wins, applied at the boundary.
        step('0, '0, 1'b1, 2);
        step(4'b0100, lens(0, 0, 4, 0), 1'b0, 0);
        idle(2);
        step('0, '0, 1'b1, 5);
        idle(2);
        step('0, '0, 1'b1, 6);
        chk("div_frozen_xfer", int'(cur_clkdiv), 2);
        drain();
        chk("div_after_pkt", int'(cur_clkdiv), 6);
        step(4'b0001, lens(1, 0, 0, 0), 1'b0, 0);
        drain();

        // Randomized traffic with occasional loads (including on final beats).
        repeat (600)
            step(N'($urandom), (N*LW)'($urandom), $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 6)));
        drain();

        // Reset after the second flit of a packet.
        step('0, '0, 1'b1, 2);
        step(4'b0100, lens(0, 0, 4, 0), 1'b0, 0);
        idle(4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_pop", int'(flit_pop), 0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("pop_in_rst", int'(flit_pop), 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        step(4'b1001, '0, 1'b0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
